serial_adder: RTL and testbench

Bit-serial ripple adder, the inverse datapath to the team's bit-serial subtractor. It loads two WIDTH-bit operands on a start pulse, adds them LSB-first through a single full adder and a carry flip-flop, one bit per clock, and presents the parallel sum with Z/N/V/C status flags. The block sits next to the subtractor as its checking path: the difference plus the subtrahend reconstructs the minuend. It also serves as the add unit in the same serial ALU.

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 172 +++++++++++++++++
 tb/tb_serial_adder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master side issues start requests with operands; the slave side
// (the adder) returns busy/done status, the parallel sum and the flags.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             st;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output st, a, b,
    input  busy, done, sum, flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
    input  st, a, b,
    output busy, done, sum, flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full adder plus a carry flip-flop, LSB first.
// A start in IDLE captures A/B, WIDTH shift cycles follow, and the final
// shift edge commits the parallel sum and Z/N/V/C flags, which then hold
// until the next commit or reset. Done pulses for one cycle after commit.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  serial_adder_if.slave  io_bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Carry out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Sum bit of a full adder.
  function automatic logic xor3(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic             r_cy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;

  logic             w_bit_s;
  logic             w_cy_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_last;

  assign w_bit_s   = xor3(r_a_sr[0], r_b_sr[0], r_cy);
  assign w_cy_nxt  = maj3(r_a_sr[0], r_b_sr[0], r_cy);
  assign w_acc_nxt = {w_bit_s, r_acc[WIDTH-1:1]};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // State register; reset forces IDLE and abandons any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is honoured only in IDLE, so requests in SHIFT/DONE are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.st) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Serial datapath: load operands on start, then one full-adder step per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sr  <= {WIDTH{1'b0}};
      r_b_sr  <= {WIDTH{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
      r_cy    <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_a_sr  <= io_bus.a;
            r_b_sr  <= io_bus.b;
            r_cy    <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            // Operand signs are kept for the overflow flag since the shifters lose them.
            r_a_msb <= io_bus.a[WIDTH-1];
            r_b_msb <= io_bus.b[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          r_acc  <= w_acc_nxt;
          r_cy   <= w_cy_nxt;
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  // Result commit on the final shift edge; sum and flags hold otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= {WIDTH{1'b0}};
      r_c   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_v   <= 1'b0;
    end else if ((r_state == ST_SHIFT) && w_last) begin
      r_sum <= w_acc_nxt;
      r_c   <= w_cy_nxt;
      r_z   <= (w_acc_nxt == {WIDTH{1'b0}});
      r_n   <= w_acc_nxt[WIDTH-1];
      r_v   <= (r_a_msb == r_b_msb) && (w_acc_nxt[WIDTH-1] != r_a_msb);
    end
  end

  // Registered status, decoded from the upcoming state so it aligns with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_SHIFT);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign io_bus.busy   = r_busy;
  assign io_bus.done   = r_done;
  assign io_bus.sum    = r_sum;
  assign io_bus.flag_c = r_c;
  assign io_bus.flag_z = r_z;
  assign io_bus.flag_n = r_n;
  assign io_bus.flag_v = r_v;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares whenever Done is seen.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] sum;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t mon_e;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic z,
                              input logic n, input logic v);
    exp_t e;
    e.sum = s; e.c = c; e.z = z; e.n = n; e.v = v;
    return e;
  endfunction

  // Plain 9-bit add used for the streaming vectors.
  function automatic exp_t add_ref(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {1'b0, b};
    return mk(t[7:0], t[8], (t[7:0] == 8'h00), t[7],
              (a[7] == b[7]) && (t[7] != a[7]));
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("busy_with_done", {31'd0, bus.busy}, 32'd0);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got Done with sum 0x%0h, expected no Done at %0t", bus.sum, $time);
      end else begin
        mon_e = q.pop_front();
        chk("sum",    {24'd0, bus.sum},    {24'd0, mon_e.sum});
        chk("flag_c", {31'd0, bus.flag_c}, {31'd0, mon_e.c});
        chk("flag_z", {31'd0, bus.flag_z}, {31'd0, mon_e.z});
        chk("flag_n", {31'd0, bus.flag_n}, {31'd0, mon_e.n});
        chk("flag_v", {31'd0, bus.flag_v}, {31'd0, mon_e.v});
      end
    end
  end

  // One operation from IDLE, with latency checks; returns at a negedge in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    q.push_back(e);
    bus.a = a; bus.b = b; bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0; bus.a = ~a; bus.b = ~b;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    repeat (W - 1) @(negedge clk);
    chk("no_early_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk("done_at_latency", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({name, "_sum"},  {24'd0, bus.sum}, 32'd0);
    chk({name, "_flags"}, {28'd0, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [8];
    logic [7:0] m, s, d, a, b;
    vals = '{8'h00, 8'h01, 8'h34, 8'h7F, 8'h80, 8'hC3, 8'hF7, 8'hFF};
    bus.st = 1'b0; bus.a = 8'h00; bus.b = 8'h00;

    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Hand-computed directed vectors.
    run_op(8'h34, 8'hF7, mk(8'h2B, 1'b1, 1'b0, 1'b0, 1'b0));
    run_op(8'h3D, 8'hF7, mk(8'h34, 1'b1, 1'b0, 1'b0, 1'b0));
    run_op(8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
    run_op(8'h80, 8'h80, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b1));
    run_op(8'h00, 8'h00, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    run_op(8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    run_op(8'h40, 8'h40, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b1));

    // Subtractor inverse: (m - s) + s must give back m.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m = vals[i];
        s = vals[j];
        d = m - s;
        run_op(d, s, mk(m, (s > m), (m == 8'h00), m[7],
                        (d[7] == s[7]) && (m[7] != d[7])));
      end
    end

    // Start requests during SHIFT and during DONE are ignored.
    q.push_back(mk(8'h2B, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.a = 8'h34; bus.b = 8'hF7; bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    repeat (2) @(negedge clk);
    bus.a = 8'h11; bus.b = 8'h22; bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_start_done", {31'd0, bus.done}, 32'd1);
    bus.a = 8'h55; bus.b = 8'h66; bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    chk("st_in_done_ignored", {31'd0, bus.busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("busy_idle_after", {31'd0, bus.busy}, 32'd0);

    // Back-to-back with St held high and operands changing every cycle.
    for (int i = 0; i < 40; i++) begin
      a = 8'(i * 37 + 5);
      b = 8'(i * 91 + 200);
      if (i > 0) chk("b2b_done_cadence", {31'd0, bus.done}, {31'd0, (i % 10 == 9)});
      bus.a = a; bus.b = b; bus.st = 1'b1;
      if (i % 10 == 0) q.push_back(add_ref(a, b));
      @(negedge clk);
    end
    bus.st = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_idle_after", {31'd0, bus.busy}, 32'd0);

    // Reset four edges into an operation: cleared outputs, no Done.
    bus.a = 8'h12; bus.b = 8'h34; bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_cleared("midreset");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset_idle", {31'd0, bus.busy}, 32'd0);
    run_op(8'h34, 8'hF7, mk(8'h2B, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
